da_accumulator: RTL and testbench
=================================

// Module: da_accumulator
// PURPOSE
//  Downstream consumer of the 8-read-port coefficient sram in the distributed-arithmetic FIR.
//  Each beat: sums Q7..Q0 (one partial-product lookup per bit slice) and shift-accumulates
//  bit-serially, LSB first, over XW beats. Emits one filter output y per sample.
//  Sits between sram read ports and the output sample register/writer.
// PARAMETERS
//  QW    20  width of each sram read word Q7..Q0 (unsigned)
//  XW    16  input sample width = beats per output sample
//  localparam SW = QW+3 (8-way sum width); YW = SW+XW+1 = 40 (signed output width)
// PORTS
//  clk      in   1       rising-edge clock
//  rst_n    in   1       asynchronous active-low reset
//  start    in   1       begin new output sample; accepted only when busy==0
//  q_valid  in   1       Q7..Q0 hold a valid bit-slice beat this cycle
//  Q7..Q0   in   QW each sram read data, unsigned
//  y        out  YW      signed result, held until next result
//  y_valid  out  1       one-cycle pulse, y updated
//  busy     out  1       state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, y=0, y_valid=0, busy=0, acc=0, beat cnt=0, pipe regs 0.
//  FSM: IDLE -> ACCUM on start; ACCUM -> FLUSH on XW-th accepted beat; FLUSH -> IDLE after drain.
//  IDLE: q_valid ignored. start=1 -> acc<=0, cnt<=0, state<=ACCUM. start+q_valid same edge:
//   beat discarded; first counted beat is the next q_valid.
//  ACCUM: each edge with q_valid=1: stage1 s_reg<=Q7+..+Q0 (zero-extended, SW bits, no overflow),
//   k_reg<=cnt, v_reg<=1; cnt<=cnt+1. q_valid=0: v_reg<=0, nothing counted (stalls any length).
//  Stage2 (edge after stage1, when v_reg): acc<=acc+(s_reg<<k_reg); if signed mode and
//   k_reg==XW-1: acc<=acc-(s_reg<<k_reg). acc is YW-bit two's complement; never wraps for legal inputs.
//  Latency: last beat sampled at edge T -> acc final at T+1 -> at T+2 y<=acc, y_valid<=1,
//   state<=IDLE, busy<=0. y_valid high exactly one cycle.
//  start while busy=1: ignored (no effect on acc/cnt). start on the y_valid cycle: accepted
//   (state already IDLE); y holds old value until the next y_valid.
//  q_valid in FLUSH: ignored. Q values only sampled when q_valid=1 in ACCUM.
//  rst_n low mid-ACCUM/FLUSH: partial result discarded, all outputs return to reset values;
//   no y_valid produced for the aborted sample.
// CONFIGURATION
//  DA_ACC_SIGNED_EN defined: input samples two's complement; beat XW-1 (sign slice) is subtracted.
//  DA_ACC_SIGNED_EN undefined: unsigned samples; all XW beats added, y always >= 0.
//  Port list, latency and FSM identical in both builds.
// TESTING
//  1 Reset: rst_n=0 after 5 beats of ACCUM -> y=0, y_valid=0, busy=0; next start + 16 beats of
//    Q*=1 gives normal result (test 2 value).
//  2 All Q*=1 for 16 beats (s=8) -> unsigned y=524280; signed y=-8.
//  3 Beat0 Q0=5, all else 0; beats1..15 all zero -> y=5 in both builds.
//  4 All Q*=20'hFFFFF for 16 beats (s=8388600) -> unsigned y=549746901000; signed y=-8388600.
//  5 Test 2 stimulus with 3 idle cycles between beats and start pulsed mid-ACCUM -> same y;
//    y_valid exactly 2 cycles after last beat; extra start has no effect.
//  6 start asserted in y_valid cycle, then test 3 stimulus -> second y_valid with y=5; y holds
//    first result until then; no beat lost or double-counted.

Source files
------------

// File: rtl/da_accumulator.sv
// rtl/da_accumulator.sv - distributed-arithmetic shift-accumulator behind the 8-port coefficient sram
// Optional feature macro: DA_ACC_SIGNED_EN (two's complement samples, sign slice subtracted)
module da_accumulator #(
    parameter int QW = 20,
    parameter int XW = 16,
    localparam int SW = QW + 3,
    localparam int YW = SW + XW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 q_valid,
    input  logic [QW-1:0]        Q7,
    input  logic [QW-1:0]        Q6,
    input  logic [QW-1:0]        Q5,
    input  logic [QW-1:0]        Q4,
    input  logic [QW-1:0]        Q3,
    input  logic [QW-1:0]        Q2,
    input  logic [QW-1:0]        Q1,
    input  logic [QW-1:0]        Q0,
    output logic signed [YW-1:0] y,
    output logic                 y_valid,
    output logic                 busy
);
    localparam int KW = (XW > 1) ? $clog2(XW) : 1;

`ifdef DA_ACC_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

    state_t               state_q, state_d;
    logic [KW-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]        s_q, s_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 v_q, v_d;
    logic signed [YW-1:0] acc_q, acc_d;
    logic signed [YW-1:0] y_q, y_d;
    logic                 y_valid_q, y_valid_d;
    logic                 busy_q, busy_d;
    logic [SW-1:0]        slice_sum;
    logic signed [YW-1:0] term;

    assign slice_sum = SW'(Q0) + SW'(Q1) + SW'(Q2) + SW'(Q3)
                     + SW'(Q4) + SW'(Q5) + SW'(Q6) + SW'(Q7);
    assign term = YW'(s_q) << k_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        k_d       = k_q;
        v_d       = v_q;
        acc_d     = acc_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        busy_d    = busy_q;

        // Stage 2 runs one edge behind stage 1, in ACCUM and while draining in FLUSH.
        if (v_q) begin
            if (SIGNED_MODE && (k_q == KW'(XW - 1)))
                acc_d = acc_q - term;
            else
                acc_d = acc_q + term;
        end

        case (state_q)
            IDLE: begin
                v_d = 1'b0;
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                    busy_d  = 1'b1;
                end
            end
            ACCUM: begin
                if (q_valid) begin
                    s_d   = slice_sum;
                    k_d   = cnt_q;
                    v_d   = 1'b1;
                    cnt_d = cnt_q + KW'(1);
                    if (cnt_q == KW'(XW - 1))
                        state_d = FLUSH;
                end else begin
                    v_d = 1'b0;
                end
            end
            FLUSH: begin
                v_d = 1'b0;
                // Once the final beat has passed stage 2, acc holds the finished sample.
                if (!v_q) begin
                    y_d       = acc_q;
                    y_valid_d = 1'b1;
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                v_d     = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            s_q       <= '0;
            k_q       <= '0;
            v_q       <= 1'b0;
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            k_q       <= k_d;
            v_q       <= v_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            busy_q    <= busy_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_da_accumulator.sv
// tb/tb_da_accumulator.sv - directed self-checking bench for da_accumulator
module tb_da_accumulator;
    localparam int QW = 20;
    localparam int XW = 16;
    localparam int YW = QW + 3 + XW + 1;

`ifdef DA_ACC_SIGNED_EN
    localparam longint EXP_ONES = -64'sd8;
    localparam longint EXP_MAX  = -64'sd8388600;
`else
    localparam longint EXP_ONES = 64'sd524280;
    localparam longint EXP_MAX  = 64'sd549746901000;
`endif

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 q_valid;
    logic [QW-1:0]        Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0;
    logic signed [YW-1:0] y;
    logic                 y_valid;
    logic                 busy;

    int n_cmp;
    int n_bad;

    da_accumulator #(.QW(QW), .XW(XW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .q_valid(q_valid),
        .Q7     (Q7),
        .Q6     (Q6),
        .Q5     (Q5),
        .Q4     (Q4),
        .Q3     (Q3),
        .Q2     (Q2),
        .Q1     (Q1),
        .Q0     (Q0),
        .y      (y),
        .y_valid(y_valid),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_q(input logic [QW-1:0] q0v, input logic [QW-1:0] rest);
        Q0 = q0v;
        {Q1, Q2, Q3, Q4, Q5, Q6, Q7} = {7{rest}};
    endtask

    // One valid beat; Q lines carry junk afterwards to catch sampling while q_valid=0.
    task automatic beat(input logic [QW-1:0] q0v, input logic [QW-1:0] rest);
        set_q(q0v, rest);
        q_valid = 1'b1;
        @(posedge clk);
        #1;
        q_valid = 1'b0;
        set_q(20'hABCDE, 20'h54321);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_check(input string tag, input longint exp);
        @(posedge clk);
        #1;
        check({tag, "_yv_t1"}, 64'(y_valid), 0);
        @(posedge clk);
        #1;
        check({tag, "_yv_t2"}, 64'(y_valid), 1);
        check({tag, "_y"}, 64'(y), exp);
        check({tag, "_busy"}, 64'(busy), 0);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        q_valid = 1'b0;
        set_q('0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_y", 64'(y), 0);
        check("rst_yv", 64'(y_valid), 0);
        check("rst_busy", 64'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: reset in the middle of ACCUM
        pulse_start();
        check("t1_busy", 64'(busy), 1);
        repeat (5) beat(20'd1, 20'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_abort_y", 64'(y), 0);
        check("t1_abort_yv", 64'(y_valid), 0);
        check("t1_abort_busy", 64'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t1_no_yv", 64'(y_valid), 0);

        // Test 2: all ones; start coincident with a big beat that must be dropped
        set_q(20'hFFFFF, 20'hFFFFF);
        q_valid = 1'b1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        q_valid = 1'b0;
        for (int i = 0; i < XW; i++) beat(20'd1, 20'd1);
        finish_check("t2", EXP_ONES);
        @(posedge clk);
        #1;
        check("t2_yv_pulse", 64'(y_valid), 0);
        check("t2_y_hold", 64'(y), EXP_ONES);

        // Test 4: full-scale sram words
        pulse_start();
        for (int i = 0; i < XW; i++) beat(20'hFFFFF, 20'hFFFFF);
        finish_check("t4", EXP_MAX);

        // Test 3: single nonzero word on beat 0
        pulse_start();
        beat(20'd5, 20'd0);
        for (int i = 1; i < XW; i++) beat(20'd0, 20'd0);
        finish_check("t3", 5);

        // Test 5: stalled beats with a stray start mid-ACCUM
        pulse_start();
        for (int i = 0; i < XW; i++) begin
            beat(20'd1, 20'd1);
            if (i != XW - 1) begin
                for (int j = 0; j < 3; j++) begin
                    start = (i == 7 && j == 1);
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
        end
        check("t5_busy", 64'(busy), 1);
        finish_check("t5", EXP_ONES);

        // Test 6: start accepted in the y_valid cycle
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t6_busy", 64'(busy), 1);
        check("t6_yv_low", 64'(y_valid), 0);
        beat(20'd5, 20'd0);
        for (int i = 1; i < XW; i++) beat(20'd0, 20'd0);
        check("t6_y_hold", 64'(y), EXP_ONES);
        finish_check("t6", 5);
        @(posedge clk);
        #1;
        check("t6_yv_pulse", 64'(y_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
